// File: rtl/cpu_bus_dtack_if.sv
// ---------------------------------------------------------------------------
// cpu_bus_dtack_if
//
// Groups the 68000 bus-cycle signals seen by the DTACK/BERR controller.
//
//   cpu_as_n, cpu_ds_n          68000 address strobe and {UDS,LDS} strobes
//   ROMn .. CCHIPn              active-low chip selects from the decoder
//   vram_ready                  video RAM port granted (level)
//   rom_ack                     SDRAM arbiter has ROM data valid (level)
//   rom_req                     ROM fetch request (level)
//   cpu_dtack_n, cpu_berr_n     cycle termination back to the CPU
//   bus_busy                    controller is inside a bus cycle
//
// master: the CPU / decoder / arbiter side that drives strobes and selects.
// slave : the controller (cpu_bus_dtack).
// ---------------------------------------------------------------------------
interface cpu_bus_dtack_if;
    logic       cpu_as_n;
    logic [1:0] cpu_ds_n;
    logic       ROMn;
    logic       WORKn;
    logic       SCREENn;
    logic       COLORn;
    logic       OBJECTn;
    logic       IO0n;
    logic       IO1n;
    logic       SOUNDn;
    logic       EXTENSIONn;
    logic       PRIORITYn;
    logic       CCHIPn;
    logic       vram_ready;
    logic       rom_ack;
    logic       rom_req;
    logic       cpu_dtack_n;
    logic       cpu_berr_n;
    logic       bus_busy;

    modport master (
        output cpu_as_n,
        output cpu_ds_n,
        output ROMn,
        output WORKn,
        output SCREENn,
        output COLORn,
        output OBJECTn,
        output IO0n,
        output IO1n,
        output SOUNDn,
        output EXTENSIONn,
        output PRIORITYn,
        output CCHIPn,
        output vram_ready,
        output rom_ack,
        input  rom_req,
        input  cpu_dtack_n,
        input  cpu_berr_n,
        input  bus_busy
    );

    modport slave (
        input  cpu_as_n,
        input  cpu_ds_n,
        input  ROMn,
        input  WORKn,
        input  SCREENn,
        input  COLORn,
        input  OBJECTn,
        input  IO0n,
        input  IO1n,
        input  SOUNDn,
        input  EXTENSIONn,
        input  PRIORITYn,
        input  CCHIPn,
        input  vram_ready,
        input  rom_ack,
        output rom_req,
        output cpu_dtack_n,
        output cpu_berr_n,
        output bus_busy
    );
endinterface

// File: rtl/cpu_bus_dtack.sv
// ---------------------------------------------------------------------------
// cpu_bus_dtack
//
// 68000 bus-cycle controller sitting right after the address decoder.
// Latches the chip selects when a cycle starts, then terminates the cycle
// with DTACK after a per-region wait, or with BERR when nothing answers.
// ROM accesses run a req/ack handshake with the SDRAM arbiter; video
// accesses (SCREEN/OBJECT/COLOR) wait for the video RAM port grant first.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   bus       cpu_bus_dtack_if.slave: strobes, chip selects, vram_ready,
//             rom_ack in; rom_req, cpu_dtack_n, cpu_berr_n, bus_busy out
//
// Parameters:
//   WS_WORK         wait cycles before DTACK for work RAM
//   WS_IO           wait cycles for IO0/IO1/SOUND/EXTENSION/PRIORITY/CCHIP
//   WS_VIDEO        wait cycles for video regions, counted after vram_ready
//   TIMEOUT_CYCLES  cycles spent in TIMEOUT before BERR (8-bit counter)
// ---------------------------------------------------------------------------
module cpu_bus_dtack #(
    parameter int unsigned WS_WORK        = 0,
    parameter int unsigned WS_IO          = 2,
    parameter int unsigned WS_VIDEO       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic           clk,
    input  logic           reset_n,
    cpu_bus_dtack_if.slave bus
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int SEL_W = 11;

    // Bit positions in the active-high select vector.
    localparam int SEL_ROM     = 10;
    localparam int SEL_WORK    = 9;
    localparam int SEL_VID_HI  = 8;   // SCREEN
    localparam int SEL_VID_LO  = 6;   // OBJECT
    localparam int SEL_IO_HI   = 5;   // IO0
    localparam int SEL_IO_LO   = 0;   // CCHIP

    localparam logic [7:0] WS_WORK_C  = 8'(WS_WORK);
    localparam logic [7:0] WS_IO_C    = 8'(WS_IO);
    localparam logic [7:0] WS_VIDEO_C = 8'(WS_VIDEO);
    localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DECODE    = 4'd1,
        ROM_WAIT  = 4'd2,
        ROM_DRAIN = 4'd3,
        VRAM_WAIT = 4'd4,
        WAIT      = 4'd5,
        ACK       = 4'd6,
        TIMEOUT   = 4'd7,
        BERR      = 4'd8
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t             state_reg;
    logic [SEL_W-1:0]   sel_reg;
    logic [7:0]         wait_cnt_reg;
    logic [7:0]         tmo_cnt_reg;
    logic               rom_req_reg;
    logic               dtack_n_reg;
    logic               berr_n_reg;
    logic               busy_reg;

    // -----------------------------------------------------------------------
    // Select vector (active high), ordered by decode priority from the MSB.
    // -----------------------------------------------------------------------
    logic [SEL_W-1:0] sel_n_raw;
    logic [SEL_W-1:0] sel_raw;

    assign sel_n_raw = {bus.ROMn,      bus.WORKn,
                        bus.SCREENn,   bus.COLORn,     bus.OBJECTn,
                        bus.IO0n,      bus.IO1n,       bus.SOUNDn,
                        bus.EXTENSIONn, bus.PRIORITYn, bus.CCHIPn};

    generate
        for (genvar gi = 0; gi < SEL_W; gi++) begin : g_sel_pol
            assign sel_raw[gi] = ~sel_n_raw[gi];
        end
    endgenerate

    // Region hits, taken from the copy latched at cycle start so that select
    // glitches later in the cycle cannot redirect it.
    logic hit_rom;
    logic hit_work;
    logic hit_video;
    logic hit_io;

    assign hit_rom   = sel_reg[SEL_ROM];
    assign hit_work  = sel_reg[SEL_WORK];
    assign hit_video = |sel_reg[SEL_VID_HI:SEL_VID_LO];
    assign hit_io    = |sel_reg[SEL_IO_HI:SEL_IO_LO];

    // -----------------------------------------------------------------------
    // Cycle qualifiers
    // -----------------------------------------------------------------------
    logic cycle_start;
    logic as_released;
    logic tmo_last;

    assign cycle_start = !bus.cpu_as_n && (bus.cpu_ds_n != 2'b11);
    assign as_released = bus.cpu_as_n;

    // This TIMEOUT cycle is the last one: the count of elapsed TIMEOUT cycles
    // reaches the limit on this edge. Widened by one bit so the compare can
    // never wrap, and the counter is parked at the limit afterwards.
    assign tmo_last = ({1'b0, tmo_cnt_reg} + 9'd1) >= {1'b0, TMO_LIMIT};

    // -----------------------------------------------------------------------
    // Controller FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            wait_cnt_reg <= 8'd0;
            tmo_cnt_reg  <= 8'd0;
            rom_req_reg  <= 1'b0;
            dtack_n_reg  <= 1'b1;
            berr_n_reg   <= 1'b1;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    wait_cnt_reg <= 8'd0;
                    tmo_cnt_reg  <= 8'd0;
                    if (cycle_start) begin
                        sel_reg   <= sel_raw;
                        state_reg <= DECODE;
                        busy_reg  <= 1'b1;
                    end
                end

                DECODE: begin
                    if (as_released) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (hit_rom) begin
                        state_reg   <= ROM_WAIT;
                        rom_req_reg <= 1'b1;
                    end else if (hit_work) begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= WS_WORK_C;
                    end else if (hit_video) begin
                        state_reg <= VRAM_WAIT;
                    end else if (hit_io) begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= WS_IO_C;
                    end else begin
                        state_reg   <= TIMEOUT;
                        tmo_cnt_reg <= 8'd0;
                    end
                end

                ROM_WAIT: begin
                    if (as_released) begin
                        // The arbiter may already be mid-fetch; the request
                        // is kept up until it acknowledges so the SDRAM side
                        // never sees a request withdrawn unanswered.
                        if (bus.rom_ack) begin
                            rom_req_reg <= 1'b0;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            state_reg <= ROM_DRAIN;
                        end
                    end else if (bus.rom_ack) begin
                        rom_req_reg <= 1'b0;
                        dtack_n_reg <= 1'b0;
                        state_reg   <= ACK;
                    end
                end

                ROM_DRAIN: begin
                    // New strobes are ignored here; IDLE accepts them later.
                    if (bus.rom_ack) begin
                        rom_req_reg <= 1'b0;
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                    end
                end

                VRAM_WAIT: begin
                    if (as_released) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (bus.vram_ready) begin
                        state_reg    <= WAIT;
                        wait_cnt_reg <= WS_VIDEO_C;
                    end
                end

                WAIT: begin
                    if (as_released) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (wait_cnt_reg == 8'd0) begin
                        dtack_n_reg <= 1'b0;
                        state_reg   <= ACK;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 8'd1;
                    end
                end

                ACK: begin
                    if (as_released) begin
                        dtack_n_reg <= 1'b1;
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
                    end
                end

                TIMEOUT: begin
                    if (as_released) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (tmo_last) begin
                        tmo_cnt_reg <= TMO_LIMIT;
                        berr_n_reg  <= 1'b0;
                        state_reg   <= BERR;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
                    end
                end

                BERR: begin
                    if (as_released) begin
                        berr_n_reg <= 1'b1;
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                    end
                end

                default: begin
                    state_reg    <= IDLE;
                    wait_cnt_reg <= 8'd0;
                    tmo_cnt_reg  <= 8'd0;
                    rom_req_reg  <= 1'b0;
                    dtack_n_reg  <= 1'b1;
                    berr_n_reg   <= 1'b1;
                    busy_reg     <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.rom_req     = rom_req_reg;
    assign bus.cpu_dtack_n = dtack_n_reg;
    assign bus.cpu_berr_n  = berr_n_reg;
    assign bus.bus_busy    = busy_reg;

endmodule

// File: tb/tb_cpu_bus_dtack.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_dtack
//
// Drives directed and randomized 68000 bus cycles into cpu_bus_dtack. For
// every cycle the expected output timeline is worked out from the bus rules
// (ready edge per region, abort edge, ack edge) and compared each clock.
// Edge index e counts the rising edges of one transaction; e = 0 is the edge
// where IDLE samples AS low.
// ---------------------------------------------------------------------------
module tb_cpu_bus_dtack;

    localparam int WS_WORK        = 0;
    localparam int WS_IO          = 2;
    localparam int WS_VIDEO       = 1;
    localparam int TIMEOUT_CYCLES = 255;

    localparam int K_ROM  = 0;
    localparam int K_WORK = 1;
    localparam int K_VID  = 2;
    localparam int K_IO   = 3;
    localparam int K_NONE = 4;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    cpu_bus_dtack_if bus_if ();

    cpu_bus_dtack #(
        .WS_WORK       (WS_WORK),
        .WS_IO         (WS_IO),
        .WS_VIDEO      (WS_VIDEO),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Observed event edges of the current transaction (-1 = not seen).
    int obs_dtack;
    int obs_berr;
    int obs_req_rise;
    int obs_req_fall;
    int obs_busy_fall;

    task automatic check(input string tag, input string field, input int e,
                         input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s %s @e%0d: got %0d, expected %0d", tag, field, e, act, exp);
    endtask

    // sel bit set = select asserted; order ROM,WORK,SCREEN,COLOR,OBJECT,
    // IO0,IO1,SOUND,EXTENSION,PRIORITY,CCHIP from bit 10 down.
    task automatic set_sel(input logic [10:0] s);
        {bus_if.ROMn, bus_if.WORKn, bus_if.SCREENn, bus_if.COLORn, bus_if.OBJECTn,
         bus_if.IO0n, bus_if.IO1n, bus_if.SOUNDn, bus_if.EXTENSIONn,
         bus_if.PRIORITYn, bus_if.CCHIPn} = ~s;
    endtask

    function automatic int kind_of(input logic [10:0] s);
        if (s[10])       return K_ROM;
        if (s[9])        return K_WORK;
        if (|s[8:6])     return K_VID;
        if (|s[5:0])     return K_IO;
        return K_NONE;
    endfunction

    // Edge at which the cycle would terminate if AS stayed low.
    function automatic int ready_edge(input int k, input int a, input int v);
        case (k)
            K_ROM:   return a;
            K_WORK:  return 2 + WS_WORK;
            K_IO:    return 2 + WS_IO;
            K_VID:   return v + 1 + WS_VIDEO;
            default: return 1 + TIMEOUT_CYCLES;
        endcase
    endfunction

    task automatic observe(input string tag, input int e, input bit x_dtack_low,
                           input bit x_berr_low, input bit x_req, input bit x_busy);
        @(posedge clk);
        #1;
        check(tag, "dtack_n", e, int'(bus_if.cpu_dtack_n), int'(!x_dtack_low));
        check(tag, "berr_n",  e, int'(bus_if.cpu_berr_n),  int'(!x_berr_low));
        check(tag, "rom_req", e, int'(bus_if.rom_req),     int'(x_req));
        check(tag, "busy",    e, int'(bus_if.bus_busy),    int'(x_busy));
        if (!bus_if.cpu_dtack_n && obs_dtack < 0) obs_dtack = e;
        if (!bus_if.cpu_berr_n && obs_berr < 0) obs_berr = e;
        if (bus_if.rom_req && obs_req_rise < 0) obs_req_rise = e;
        if (!bus_if.rom_req && obs_req_rise >= 0 && obs_req_fall < 0) obs_req_fall = e;
        if (!bus_if.bus_busy && obs_busy_fall < 0) obs_busy_fall = e;
    endtask

    // s: selects at e=0; h: first edge sampling AS high; a: edge rom_ack is
    // sampled; v: first edge vram_ready is sampled high; d: ROM drain edge
    // from which AS is pulled low again (0 = never); g: idle gap cycles.
    task automatic run_txn(input string tag, input logic [10:0] s, input int h,
                           input int a, input int v, input int d, input int g);
        int  k;
        int  r;
        int  end_e;
        bit  x_dt;
        bit  x_be;
        bit  x_rq;
        bit  win;
        obs_dtack = -1; obs_berr = -1; obs_req_rise = -1;
        obs_req_fall = -1; obs_busy_fall = -1;
        k = kind_of(s);
        r = ready_edge(k, a, v);
        if (k == K_ROM) end_e = (h == 1) ? 1 : ((h > a) ? h : a);
        else            end_e = h;

        for (int e = 0; e <= end_e; e++) begin
            bus_if.cpu_as_n = (e < h) ? 1'b0 : ((d > 0 && e >= d) ? 1'b0 : 1'b1);
            if (e == 0) begin
                bus_if.cpu_ds_n = 2'($urandom_range(0, 2));
                set_sel(s);
            end else begin
                bus_if.cpu_ds_n = 2'($urandom);
                set_sel(11'($urandom));
            end
            bus_if.rom_ack    = (k == K_ROM) ? (e == a) : 1'($urandom);
            bus_if.vram_ready = (k == K_VID) ? (e >= v) : 1'($urandom);

            if (k == K_ROM) begin
                x_rq = (h >= 2) && (e >= 1) && (e < a);
                x_dt = (h > a) && (e >= a) && (e < h);
                x_be = 1'b0;
            end else begin
                win  = (h > r) && (e >= r) && (e < h);
                x_dt = win && (k != K_NONE);
                x_be = win && (k == K_NONE);
                x_rq = 1'b0;
            end
            observe(tag, e, x_dt, x_be, x_rq, e < end_e);
        end

        // Idle gap: AS is either high or low with both data strobes high,
        // neither of which may start a cycle.
        for (int j = 0; j < g; j++) begin
            bus_if.cpu_as_n   = 1'($urandom);
            bus_if.cpu_ds_n   = bus_if.cpu_as_n ? 2'($urandom) : 2'b11;
            set_sel(11'($urandom));
            bus_if.rom_ack    = 1'($urandom);
            bus_if.vram_ready = 1'($urandom);
            observe({tag, "_gap"}, end_e + 1 + j, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [10:0] s;
        int cls, k, a, v, r, h, d, g;

        reset_n = 1'b0;
        bus_if.cpu_as_n   = 1'b1;
        bus_if.cpu_ds_n   = 2'b11;
        bus_if.rom_ack    = 1'b0;
        bus_if.vram_ready = 1'b0;
        set_sel(11'd0);
        obs_dtack = -1; obs_berr = -1; obs_req_rise = -1;
        obs_req_fall = -1; obs_busy_fall = -1;
        repeat (3) @(posedge clk);
        #1;
        check("reset", "dtack_n", -1, int'(bus_if.cpu_dtack_n), 1);
        check("reset", "berr_n",  -1, int'(bus_if.cpu_berr_n),  1);
        check("reset", "rom_req", -1, int'(bus_if.rom_req),     0);
        check("reset", "busy",    -1, int'(bus_if.bus_busy),    0);
        @(negedge clk);
        reset_n = 1'b1;
        observe("post_reset", 0, 0, 0, 0, 0);

        // AS low with both data strobes high must not start a cycle.
        bus_if.cpu_as_n = 1'b0;
        bus_if.cpu_ds_n = 2'b11;
        set_sel(11'b010_0000_0000);
        for (int j = 0; j < 3; j++) observe("ds_idle", j, 0, 0, 0, 0);
        bus_if.cpu_as_n = 1'b1;
        observe("ds_idle", 3, 0, 0, 0, 0);

        // Work RAM read, zero wait states.
        run_txn("work", 11'b010_0000_0000, 6, 0, 0, 0, 1);
        check("work", "dtack_edge", -1, obs_dtack, 2);
        check("work", "busy_fall",  -1, obs_busy_fall, 6);
        check("work", "berr_edge",  -1, obs_berr, -1);

        // ROM read, ack sampled 10 cycles after the request rises.
        run_txn("rom", 11'b100_0000_0000, 14, 11, 0, 0, 1);
        check("rom", "req_rise",   -1, obs_req_rise, 1);
        check("rom", "req_fall",   -1, obs_req_fall, 11);
        check("rom", "dtack_edge", -1, obs_dtack, 11);

        // Video write, vram_ready low for 5 VRAM_WAIT cycles.
        run_txn("video", 11'b001_0000_0000, 12, 0, 7, 0, 1);
        check("video", "dtack_edge", -1, obs_dtack, 9);

        // IO access, two wait states.
        run_txn("io", 11'b000_0000_0001, 7, 0, 0, 0, 1);
        check("io", "dtack_edge", -1, obs_dtack, 4);

        // Unmapped access.
        run_txn("unmapped", 11'd0, 260, 0, 0, 0, 1);
        check("unmapped", "berr_edge",  -1, obs_berr, 256);
        check("unmapped", "dtack_edge", -1, obs_dtack, -1);
        check("unmapped", "busy_fall",  -1, obs_busy_fall, 260);

        // ROM abort 3 cycles into ROM_WAIT, AS pulled low again mid-drain,
        // then a work cycle immediately after the drain completes.
        run_txn("rom_abort", 11'b100_0000_0000, 4, 9, 0, 6, 0);
        check("rom_abort", "req_fall",   -1, obs_req_fall, 9);
        check("rom_abort", "dtack_edge", -1, obs_dtack, -1);
        check("rom_abort", "busy_fall",  -1, obs_busy_fall, 9);
        run_txn("after_drain", 11'b010_0000_0000, 5, 0, 0, 0, 1);
        check("after_drain", "dtack_edge", -1, obs_dtack, 2);

        // Asynchronous reset while DTACK is asserted.
        set_sel(11'b010_0000_0000);
        bus_if.cpu_as_n = 1'b0;
        bus_if.cpu_ds_n = 2'b00;
        observe("rst_mid", 0, 0, 0, 0, 1);
        observe("rst_mid", 1, 0, 0, 0, 1);
        observe("rst_mid", 2, 1, 0, 0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid", "async_dtack_n", -1, int'(bus_if.cpu_dtack_n), 1);
        check("rst_mid", "async_rom_req", -1, int'(bus_if.rom_req), 0);
        check("rst_mid", "async_busy",    -1, int'(bus_if.bus_busy), 0);
        bus_if.cpu_as_n = 1'b1;
        bus_if.cpu_ds_n = 2'b11;
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 3; j++) observe("rst_idle", j, 0, 0, 0, 0);
        run_txn("rst_after", 11'b010_0000_0000, 4, 0, 0, 0, 0);
        check("rst_after", "dtack_edge", -1, obs_dtack, 2);

        // Randomized cycles.
        for (int t = 0; t < 250; t++) begin
            cls = $urandom_range(0, 12);
            s   = 11'($urandom);
            if (cls <= 2) begin
                s[10] = 1'b1;
            end else if (cls <= 5) begin
                s[10] = 1'b0; s[9] = 1'b1;
            end else if (cls <= 8) begin
                s[10:9] = 2'b00; s[6 + $urandom_range(0, 2)] = 1'b1;
            end else if (cls <= 11) begin
                s[10:6] = 5'd0; s[$urandom_range(0, 5)] = 1'b1;
            end else begin
                s = 11'd0;
            end
            k = kind_of(s);
            a = $urandom_range(2, 11);
            v = $urandom_range(2, 9);
            r = ready_edge(k, a, v);
            if ($urandom_range(0, 3) == 0) h = $urandom_range(1, r);
            else                           h = r + $urandom_range(1, 5);
            d = 0;
            if (k == K_ROM && h >= 2 && h < a && $urandom_range(0, 1) == 1)
                d = $urandom_range(h + 1, a);
            g = $urandom_range(0, 2);
            run_txn("rand", s, h, a, v, d, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
